// File: rtl/rr_burst_arbiter_if.sv
// Handshake bundle between the requester front-ends, the burst arbiter
// and the shared resource's beat handshake.
// slave  : arbiter side (consumes requests/beats, produces grant)
// master : environment side (drives requests/beats, observes grant)
interface rr_burst_arbiter_if #(
  parameter int N    = 4,
  parameter int LENW = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]      req;
  logic [N*LENW-1:0] req_len;
  logic              beat_valid;
  logic [N-1:0]      grant;
  logic              grant_valid;
  logic [IW-1:0]     owner_idx;
  logic              last_beat;
  logic              timeout_err;

  modport slave (
    input  req, req_len, beat_valid,
    output grant, grant_valid, owner_idx, last_beat, timeout_err
  );

  modport master (
    output req, req_len, beat_valid,
    input  grant, grant_valid, owner_idx, last_beat, timeout_err
  );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: locks a grant for a whole burst of
// (req_len+1) beats, then releases for one idle cycle and rotates priority.
// Optional stall watchdog enabled by defining RR_BURST_ARB_TIMEOUT_EN.
module rr_burst_arbiter #(
  parameter int N       = 4,
  parameter int LENW    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rstn,
  rr_burst_arbiter_if.slave   bus
);
  localparam int IW = $clog2(N);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [N-1:0]    r_grant;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_ptr;
  logic [LENW-1:0] r_beat_cnt;
  logic [LENW-1:0] r_len;

  logic            w_found;
  logic [IW-1:0]   w_pick;
  logic [LENW-1:0] w_pick_len;
  logic [IW-1:0]   w_ptr_nxt;
  logic            w_grant_valid;
  logic            w_last;
  logic            w_abort;

  assign w_grant_valid = |r_grant;
  assign w_last        = w_grant_valid && bus.beat_valid && (r_beat_cnt == r_len);
  // Explicit wrap keeps the rotation correct for non-power-of-2 N.
  assign w_ptr_nxt     = (r_owner == IW'(N - 1)) ? '0 : r_owner + 1'b1;

  // Cyclic search for the first request at or after the priority pointer.
  always_comb begin
    logic [IW:0] sum;
    w_found = 1'b0;
    w_pick  = '0;
    sum     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, r_ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      if (!w_found && bus.req[sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = sum[IW-1:0];
      end
    end
  end

  // Select the winning requester's burst-length field.
  always_comb begin
    w_pick_len = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick == IW'(i)) w_pick_len = bus.req_len[i*LENW +: LENW];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: grant on any request, release on last beat or abort.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next_state = ACTIVE;
      ACTIVE:  if (w_last || w_abort) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Grant, owner, pointer and beat counter updates.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant    <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_beat_cnt <= '0;
      r_len      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant    <= {{(N-1){1'b0}}, 1'b1} << w_pick;
            r_owner    <= w_pick;
            r_len      <= w_pick_len;
            r_beat_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (w_last || w_abort) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_nxt;
          end else if (bus.beat_valid) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_grant <= '0;
      endcase
    end
  end

`ifdef RR_BURST_ARB_TIMEOUT_EN
  localparam int SW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [SW-1:0] r_stall_cnt;
  logic          r_timeout_err;

  // A beat in the limit cycle wins over the abort.
  assign w_abort = (r_state == ACTIVE) && !bus.beat_valid &&
                   (r_stall_cnt == SW'(TIMEOUT - 1));

  // Consecutive-stall counter and one-cycle abort pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_abort;
      if (r_state != ACTIVE || bus.beat_valid || w_abort) r_stall_cnt <= '0;
      else                                                r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  assign w_abort         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.grant       = r_grant;
  assign bus.grant_valid = w_grant_valid;
  assign bus.owner_idx   = r_owner;
  assign bus.last_beat   = w_last;
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Scoreboard bench for rr_burst_arbiter: the stimulus process pushes the
// expected per-cycle response from a burst-level reference model; a
// negedge monitor pops and compares.
module tb_rr_burst_arbiter;
  localparam int N       = 4;
  localparam int LENW    = 4;
  localparam int TIMEOUT = 16;
  localparam int IW      = $clog2(N);
`ifdef RR_BURST_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  rr_burst_arbiter_if #(.N(N), .LENW(LENW)) bus ();

  rr_burst_arbiter #(.N(N), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  typedef struct {
    logic [N-1:0]  g;
    logic [IW-1:0] own;
    logic          lb;
    logic          to;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  bit   started = 1'b0;

  // Reference model: who owns the resource and how many beats remain.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_left  = 0;
  int m_stall = 0;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  function automatic logic [N*LENW-1:0] mklen(input int l0, l1, l2, l3);
    logic [N*LENW-1:0] v;
    v = '0;
    v[0*LENW +: LENW] = LENW'(l0);
    v[1*LENW +: LENW] = LENW'(l1);
    v[2*LENW +: LENW] = LENW'(l2);
    v[3*LENW +: LENW] = LENW'(l3);
    return v;
  endfunction

  task automatic step(input logic rn, input logic [N-1:0] r,
                      input logic [N*LENW-1:0] l, input logic b);
    exp_t e;
    @(posedge clk);
    #1;
    rstn           = rn;
    bus.req        = r;
    bus.req_len    = l;
    bus.beat_valid = b;
    if (!rn) begin
      m_busy = 1'b0; m_owner = 0; m_left = 0; m_stall = 0; m_ptr = 0; m_to = 1'b0;
    end
    e.g   = m_busy ? (N'(1) << m_owner) : '0;
    e.own = m_owner[IW-1:0];
    e.lb  = m_busy && b && (m_left == 1);
    e.to  = m_to;
    q.push_back(e);
    started = 1'b1;
    if (rn) begin
      m_to = 1'b0;
      if (m_busy) begin
        if (b) begin
          m_left--;
          m_stall = 0;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
          end
        end else begin
          m_stall++;
          if (TO_EN && m_stall == TIMEOUT) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
            m_to   = 1'b1;
          end
        end
      end else if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          int idx = (m_ptr + k) % N;
          if (r[idx]) begin
            m_owner = idx;
            break;
          end
        end
        m_left  = int'(l[m_owner*LENW +: LENW]) + 1;
        m_busy  = 1'b1;
        m_stall = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
      end else begin
        mon_e = q.pop_front();
        if (bus.grant !== mon_e.g || bus.grant_valid !== (|mon_e.g) ||
            bus.owner_idx !== mon_e.own || bus.last_beat !== mon_e.lb ||
            bus.timeout_err !== mon_e.to) begin
          errors++;
          $display("FAIL cycle_check at %0t: got grant=%b gv=%b own=%0d last=%b to=%b, want grant=%b gv=%b own=%0d last=%b to=%b",
                   $time, bus.grant, bus.grant_valid, bus.owner_idx, bus.last_beat, bus.timeout_err,
                   mon_e.g, |mon_e.g, mon_e.own, mon_e.lb, mon_e.to);
        end
      end
    end
  end

  initial begin
    logic [N-1:0]      r;
    logic [N*LENW-1:0] l;
    logic              b;
    int                pct;
    rstn           = 1'b0;
    bus.req        = '0;
    bus.req_len    = '0;
    bus.beat_valid = 1'b0;

    // Reset state, then a single 4-beat burst from requester 2.
    repeat (2) step(1'b0, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b1);
    step(1'b1, 4'b0100, mklen(0, 0, 3, 0), 1'b1);
    repeat (6) step(1'b1, '0, mklen(0, 0, 3, 0), 1'b1);

    // Full rotation with single-beat bursts from a fresh pointer.
    step(1'b0, '0, '0, 1'b0);
    repeat (10) step(1'b1, 4'b1111, '0, 1'b1);

    // Stalls and dropped request mid-burst.
    repeat (2) step(1'b1, '0, '0, 1'b0);
    step(1'b1, 4'b0010, mklen(0, 2, 0, 0), 1'b1);
    step(1'b1, '0, '0, 1'b1);
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, '0, '0, 1'b1);
    step(1'b1, '0, '0, 1'b1);
    repeat (2) step(1'b1, '0, '0, 1'b1);

    // Length change after capture is ignored.
    step(1'b1, 4'b0001, mklen(1, 0, 0, 0), 1'b1);
    repeat (5) step(1'b1, 4'b0001, mklen(7, 0, 0, 0), 1'b1);
    step(1'b1, '0, '0, 1'b0);

    // Asynchronous reset during an 8-beat burst from requester 3.
    step(1'b1, 4'b1000, mklen(0, 0, 0, 7), 1'b1);
    step(1'b1, 4'b1000, mklen(0, 0, 0, 7), 1'b1);
    step(1'b0, 4'b1001, mklen(0, 0, 0, 7), 1'b1);
    step(1'b0, 4'b1001, mklen(0, 0, 0, 7), 1'b0);
    step(1'b1, 4'b1001, mklen(0, 0, 0, 7), 1'b0);
    repeat (3) step(1'b1, '0, '0, 1'b1);

    // Long stall: watchdog abort when enabled, indefinite hold otherwise.
    step(1'b1, 4'b0010, mklen(0, 3, 1, 0), 1'b0);
    repeat (22) step(1'b1, 4'b0101, mklen(0, 3, 1, 0), 1'b0);
    repeat (8) step(1'b1, '0, mklen(0, 3, 1, 0), 1'b1);

    // Randomised traffic in three beat-density phases.
    for (int i = 0; i < 2400; i++) begin
      pct = (i < 900) ? 80 : (i < 1600) ? 40 : 6;
      r   = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
      l   = (N*LENW)'($urandom());
      b   = ($urandom_range(0, 99) < pct);
      step(($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1, r, l, b);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- Round-robin arbiter that shares one burst-capable resource (a bus or memory port) among N requesters.
- Unlike a single-cycle arbiter, a grant is locked for a whole burst. The block counts beats accepted by the resource, then releases the grant and rotates priority.
- It sits between the requester front-ends and the shared resource's beat handshake.

Parameters:
- N, 4, number of requesters (N >= 2).
- LENW, 4, width of each burst-length field; a burst is 1 to 2^LENW beats.
- TIMEOUT, 16, stall-cycle limit for the optional watchdog (TIMEOUT >= 2).

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- req  input  N  request vector; bit i = requester i.
- req_len  input  N*LENW  burst length minus 1; requester i uses bits [i*LENW +: LENW].
- beat_valid  input  1  resource accepted one beat of the current burst this cycle.
- grant  output  N  one-hot registered grant, or all zero.
- grant_valid  output  1  equals |grant.
- owner_idx  output  $clog2(N)  index of the current grant owner; holds the last value when idle.
- last_beat  output  1  combinational; equals grant_valid && beat_valid && (beat_cnt == len_q).
- timeout_err  output  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset values:
  - grant=0, grant_valid=0, owner_idx=0, timeout_err=0.
  - Internal: ptr=0, beat_cnt=0, len_q=0, stall_cnt=0, state=IDLE.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit of req at or after ptr, searching cyclically upward with wrap N-1 -> 0.
  - Next cycle: grant bit = selected index; owner_idx = index; len_q = that requester's req_len slice; beat_cnt=0.
  - Go to ACTIVE.
  - Latency: req asserted in cycle t gives grant in cycle t+1.
- State ACTIVE:
  - Grant is held regardless of req; deasserting req mid-burst is ignored.
  - req_len changes after capture are ignored.
  - On beat_valid with beat_cnt != len_q: beat_cnt increments.
  - On beat_valid with beat_cnt == len_q: last_beat=1 that cycle. Next cycle: grant=0, ptr=(owner_idx+1) mod N, state=IDLE.
  - beat_valid=0: stall; counters hold except stall_cnt.
  - beat_valid while grant_valid=0 is ignored.
- Inter-burst gap:
  - At least one IDLE cycle (grant=0) separates consecutive grants.
  - Arbitration happens in that IDLE cycle using the current req and updated ptr.
  - Back-to-back peak throughput is therefore 1 grant per (len+2) cycles.
- Fairness:
  - With all requesters continuously asserting, grants cycle 0,1,...,N-1,0,...
  - No requester waits more than N-1 bursts.
- ptr arithmetic:
  - The modulo-N wrap must be correct for non-power-of-2 N; e.g. N=3, owner 2 -> ptr 0.
  - Width is $clog2(N).
- len_q = 2^LENW - 1 gives the maximum burst of 2^LENW beats; beat_cnt never overflows.
- Reset asserted mid-burst:
  - All state returns to reset values asynchronously; grant drops immediately.
  - After release, arbitration restarts from ptr=0.
- grant is always one-hot or zero. owner_idx is consistent with grant whenever grant_valid=1.

Optional Feature:
- Macro: RR_BURST_ARB_TIMEOUT_EN.
- Defined:
  - stall_cnt counts consecutive ACTIVE cycles with beat_valid=0; it clears on any beat and on entry to ACTIVE.
  - When stall_cnt reaches TIMEOUT-1 and beat_valid=0 again, the burst is aborted.
  - Abort effects next cycle: timeout_err=1 for one cycle, grant=0, ptr=(owner_idx+1) mod N, state=IDLE.
  - A beat in the same cycle as the limit counts as a beat; no abort.
- Not defined:
  - No stall_cnt logic; timeout_err is tied 0.
  - A burst waits indefinitely for beats.

Test Plan:
1. Reset, then req=4'b0100 with len2=3, beat_valid=1 every cycle -> grant=4'b0100 one cycle after req; four beats; last_beat on the 4th beat; grant=0 next cycle; ptr=3.
2. req=4'b1111 held, all len=0, beat_valid=1 -> grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001 (rotation with wrap).
3. Owner 1 with len=2, beat_valid pattern 1,0,0,1,1 and req1 dropped after grant -> grant held through stalls; last_beat on the 5th cycle of the pattern; release follows.
4. req_len slice changed mid-burst from 1 to 7 -> burst still ends after 2 beats.
5. rstn pulled low during beat 2 of an 8-beat burst from owner 3 -> grant=0 immediately; after release with req=4'b1001, grant goes to requester 0.
6. With RR_BURST_ARB_TIMEOUT_EN, TIMEOUT=16: grant then no beats for 16 cycles -> timeout_err pulse, grant=0, next grant to the next requester. Without the macro, the same stimulus holds grant indefinitely and timeout_err stays 0.
